snes_frame_sync_ctrl: RTL and testbench

Frame-synchronisation controller for the SNES-to-HDMI path, in the SNES `clk` domain. Once per frame it halts the SNES core during the DRAM refresh on a chosen line. It releases the core when the HDMI side reports its first active line. Each pause lasts an even number of cycles so PPU SDRAM access stays phase-aligned. It adds a watchdog timeout, lock tracking and per-frame pause statistics.

---
 rtl/snes_frame_sync_ctrl_if.sv | 28 ++
 rtl/snes_frame_sync_ctrl.sv | 134 +++++++++++++
 tb/tb_snes_frame_sync_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snes_frame_sync_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : snes_frame_sync_ctrl_if
//  Brief    : Bus bundle between the SNES timing source and the frame-sync
//             controller (line/refresh/HDMI inputs, pause and status outputs).
//  Revision : 1.0  initial release
// ============================================================================
interface snes_frame_sync_ctrl_if;
   logic        enable;
   logic [8:0]  ys;
   logic        snes_refresh;
   logic        hdmi_first_line;
   logic        pause_snes_for_frame_sync;
   logic        sync_locked;
   logic [15:0] pause_cycles;
   logic [7:0]  timeout_count;

   modport master (
      output enable, ys, snes_refresh, hdmi_first_line,
      input  pause_snes_for_frame_sync, sync_locked, pause_cycles, timeout_count
   );

   modport slave (
      input  enable, ys, snes_refresh, hdmi_first_line,
      output pause_snes_for_frame_sync, sync_locked, pause_cycles, timeout_count
   );
endinterface
`default_nettype wire

// File: rtl/snes_frame_sync_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : snes_frame_sync_ctrl
//  Brief    : Halts the SNES core once per frame until HDMI reports its first
//             line, keeping every pause an even number of cycles long.
//  Revision : 1.0  initial release
// ============================================================================
module snes_frame_sync_ctrl #(
   parameter logic [7:0]  SYNC_LINE    = 8'd2,
   parameter logic [7:0]  RELEASE_LINE = 8'd200,
   parameter logic [15:0] TIMEOUT      = 16'd40000,
   parameter logic [1:0]  LOCK_FRAMES  = 2'd3
) (
   input wire                    clk,
   input wire                    reset,
   snes_frame_sync_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARM   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        hdmi_meta_q, hdmi_sync_q, hdmi_prev_q;
   logic [15:0] pause_len_q, pause_len_d;
   logic        hdmi_seen_q, hdmi_seen_d;
   logic [1:0]  good_q, good_d;
   logic        pause_q, pause_d;
   logic        sync_locked_q, sync_locked_d;
   logic [15:0] pause_cycles_q, pause_cycles_d;
   logic [7:0]  timeout_count_q, timeout_count_d;

   logic w_hdmi_edge;
   logic w_trigger;
   logic w_parity_ok;
   logic w_unused_ys_msb;

   assign w_hdmi_edge     = hdmi_sync_q & ~hdmi_prev_q;
   assign w_trigger       = (bus.ys[7:0] == SYNC_LINE) && bus.snes_refresh;
   assign w_parity_ok     = pause_len_q[0];
   assign w_unused_ys_msb = bus.ys[8];

   always_comb begin
      state_d         = state_q;
      pause_len_d     = pause_len_q;
      hdmi_seen_d     = hdmi_seen_q;
      good_d          = good_q;
      pause_d         = 1'b0;
      pause_cycles_d  = pause_cycles_q;
      timeout_count_d = timeout_count_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.enable) state_d = ST_ARM;
         end
         ST_ARM: begin
            if (w_trigger) begin
               state_d     = ST_PAUSE;
               pause_d     = 1'b1;
               pause_len_d = 16'd0;
               hdmi_seen_d = 1'b0;
            end else if (!bus.enable) begin
               state_d = ST_IDLE;
            end
         end
         ST_PAUSE: begin
            pause_d = 1'b1;
            if (pause_len_q != 16'hFFFF) pause_len_d = pause_len_q + 16'd1;
            if (w_hdmi_edge) hdmi_seen_d = 1'b1;
            // pause_len odd here means pause_len+1 high cycles, i.e. an even total
            if (!bus.enable && w_parity_ok) begin
               state_d = ST_IDLE;
               pause_d = 1'b0;
            end else if ((hdmi_seen_q || w_hdmi_edge) && w_parity_ok) begin
               state_d        = ST_DONE;
               pause_d        = 1'b0;
               pause_cycles_d = pause_len_q + 16'd1;
               if (good_q != LOCK_FRAMES) good_d = good_q + 2'd1;
            end else if (pause_len_q == TIMEOUT - 16'd1) begin
               state_d        = ST_DONE;
               pause_d        = 1'b0;
               pause_cycles_d = TIMEOUT;
               good_d         = 2'd0;
               if (timeout_count_q != 8'hFF) timeout_count_d = timeout_count_q + 8'd1;
            end
         end
         ST_DONE: begin
            if (!bus.enable) state_d = ST_IDLE;
            else if (bus.ys[7:0] == RELEASE_LINE) state_d = ST_ARM;
         end
         default: state_d = ST_IDLE;
      endcase

      sync_locked_d = (good_d == LOCK_FRAMES);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         hdmi_meta_q     <= 1'b0;
         hdmi_sync_q     <= 1'b0;
         hdmi_prev_q     <= 1'b0;
         pause_len_q     <= 16'd0;
         hdmi_seen_q     <= 1'b0;
         good_q          <= 2'd0;
         pause_q         <= 1'b0;
         sync_locked_q   <= 1'b0;
         pause_cycles_q  <= 16'd0;
         timeout_count_q <= 8'd0;
      end else begin
         state_q         <= state_d;
         hdmi_meta_q     <= bus.hdmi_first_line;
         hdmi_sync_q     <= hdmi_meta_q;
         hdmi_prev_q     <= hdmi_sync_q;
         pause_len_q     <= pause_len_d;
         hdmi_seen_q     <= hdmi_seen_d;
         good_q          <= good_d;
         pause_q         <= pause_d;
         sync_locked_q   <= sync_locked_d;
         pause_cycles_q  <= pause_cycles_d;
         timeout_count_q <= timeout_count_d;
      end
   end

   assign bus.pause_snes_for_frame_sync = pause_q;
   assign bus.sync_locked               = sync_locked_q;
   assign bus.pause_cycles              = pause_cycles_q;
   assign bus.timeout_count             = timeout_count_q;

endmodule
`default_nettype wire

// File: tb/tb_snes_frame_sync_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_snes_frame_sync_ctrl
//  Brief    : Directed and randomized frames against a timestamp-based model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_snes_frame_sync_ctrl;
   localparam logic [7:0] SYNC_LINE    = 8'd2;
   localparam logic [7:0] RELEASE_LINE = 8'd200;
   localparam int         TIMEOUT      = 16;
   localparam int         LOCK_FRAMES  = 3;
   localparam int         HIST_DEPTH   = 32768;
   localparam int         M_IDLE = 0, M_ARM = 1, M_PAUSE = 2, M_DONE = 3;

   logic clk = 1'b0;
   logic reset = 1'b0;

   snes_frame_sync_ctrl_if bus_if ();

   snes_frame_sync_ctrl #(
      .SYNC_LINE    (SYNC_LINE),
      .RELEASE_LINE (RELEASE_LINE),
      .TIMEOUT      (16'(TIMEOUT)),
      .LOCK_FRAMES  (2'(LOCK_FRAMES))
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_bad    = 0;

   // Model: phase, timestamp of the trigger edge and per-edge HDMI input samples
   int m_phase, m_t0, m_good, m_tc, m_pc, cyc, hist_base;
   bit m_seen;
   bit hist [HIST_DEPTH];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic check_all();
      check_val("pause", 32'(bus_if.pause_snes_for_frame_sync), 32'(m_phase == M_PAUSE));
      check_val("locked", 32'(bus_if.sync_locked), 32'(m_good == LOCK_FRAMES));
      check_val("pause_cycles", 32'(bus_if.pause_cycles), 32'(m_pc));
      check_val("timeout_count", 32'(bus_if.timeout_count), 32'(m_tc));
   endtask

   function automatic bit samp(int k);
      return (k >= hist_base && k >= 0) ? hist[k] : 1'b0;
   endfunction

   task automatic model_reset();
      m_phase   = M_IDLE;
      m_good    = 0;
      m_tc      = 0;
      m_pc      = 0;
      m_seen    = 1'b0;
      hist_base = cyc + 1;
   endtask

   task automatic model_step();
      bit e_now;
      int hi;
      hist[cyc] = bus_if.hdmi_first_line;
      // a rising input is acted upon two edges after it is first sampled
      e_now = samp(cyc - 2) && !samp(cyc - 3);
      case (m_phase)
         M_IDLE: if (bus_if.enable) m_phase = M_ARM;
         M_ARM: begin
            if (bus_if.ys[7:0] == SYNC_LINE && bus_if.snes_refresh) begin
               m_phase = M_PAUSE;
               m_t0    = cyc;
               m_seen  = 1'b0;
            end else if (!bus_if.enable) begin
               m_phase = M_IDLE;
            end
         end
         M_PAUSE: begin
            hi = cyc - m_t0;
            if (hi % 2 == 0 && !bus_if.enable) begin
               m_phase = M_IDLE;
            end else if (hi % 2 == 0 && (m_seen || e_now)) begin
               m_pc = hi;
               if (m_good < LOCK_FRAMES) m_good++;
               m_phase = M_DONE;
            end else if (hi == TIMEOUT) begin
               m_pc = TIMEOUT;
               if (m_tc < 255) m_tc++;
               m_good  = 0;
               m_phase = M_DONE;
            end else if (e_now) begin
               m_seen = 1'b1;
            end
         end
         M_DONE: begin
            if (!bus_if.enable) m_phase = M_IDLE;
            else if (bus_if.ys[7:0] == RELEASE_LINE) m_phase = M_ARM;
         end
         default: m_phase = M_IDLE;
      endcase
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      if (cyc >= HIST_DEPTH) begin
         $display("FAIL cycle_budget: got %0d expected below %0d", cyc, HIST_DEPTH);
         $fatal(1, "cycle budget exceeded");
      end
      model_step();
      #1;
      check_all();
   endtask

   // Asynchronous reset between edges; outputs must clear before any clock
   task automatic apply_reset();
      #3 reset = 1'b1;
      #1;
      model_reset();
      check_all();
      check_val("rst_pause", 32'(bus_if.pause_snes_for_frame_sync), 32'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic rearm();
      bus_if.enable = 1'b1;
      bus_if.ys     = 9'(RELEASE_LINE);
      tick();
      bus_if.ys     = 9'd0;
      tick();
   endtask

   task automatic start_pause();
      bus_if.ys           = 9'(SYNC_LINE);
      bus_if.snes_refresh = 1'b1;
      tick();
      bus_if.ys           = 9'(SYNC_LINE) + 9'd1;
      bus_if.snes_refresh = 1'b0;
   endtask

   // Called right after the trigger edge; rise_at / drop_at are edge offsets (<0: never)
   task automatic count_pause(input int rise_at, input int drop_at, output int hi);
      hi = int'(bus_if.pause_snes_for_frame_sync);
      for (int i = 1; i <= 60; i++) begin
         if (i == rise_at) bus_if.hdmi_first_line = 1'b1;
         if (i == rise_at + 5) bus_if.hdmi_first_line = 1'b0;
         if (i == drop_at) bus_if.enable = 1'b0;
         tick();
         if (!bus_if.pause_snes_for_frame_sync) break;
         hi++;
      end
      bus_if.hdmi_first_line = 1'b0;
      bus_if.enable          = 1'b1;
   endtask

   task automatic hdmi_pulse();
      bus_if.hdmi_first_line = 1'b1;
      repeat (5) tick();
      bus_if.hdmi_first_line = 1'b0;
      repeat (4) tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int hi;
      int ln, sub, hdelay, hhigh, hgap, en_off, prev_phase;

      bus_if.enable          = 1'b0;
      bus_if.ys              = 9'd0;
      bus_if.snes_refresh    = 1'b0;
      bus_if.hdmi_first_line = 1'b0;
      cyc = 0;
      m_t0 = 0;
      #1 reset = 1'b1;
      #3;
      model_reset();
      check_all();
      @(negedge clk);
      reset = 1'b0;

      // Normal sync, edge lands on an even-length boundary
      bus_if.enable = 1'b1;
      tick();
      start_pause();
      count_pause(12, -1, hi);
      check_val("A_high_cycles", 32'(hi), 32'd14);
      check_val("A_pause_cycles", 32'(bus_if.pause_cycles), 32'd14);
      check_val("A_even", 32'(hi % 2), 32'd0);
      apply_reset();

      // Edge one cycle earlier: raw exit would be odd, so one extra cycle
      bus_if.enable = 1'b1;
      tick();
      start_pause();
      count_pause(11, -1, hi);
      check_val("B_high_cycles", 32'(hi), 32'd14);
      check_val("B_pause_cycles", 32'(bus_if.pause_cycles), 32'd14);

      // Pulses in DONE and ARM are ignored; next pause must time out
      hdmi_pulse();
      rearm();
      hdmi_pulse();
      start_pause();
      count_pause(-1, -1, hi);
      check_val("C_high_cycles", 32'(hi), 32'(TIMEOUT));
      check_val("C_pause_cycles", 32'(bus_if.pause_cycles), 32'(TIMEOUT));
      check_val("C_timeouts", 32'(bus_if.timeout_count), 32'd1);
      check_val("C_locked", 32'(bus_if.sync_locked), 32'd0);

      // Enable dropped on an odd offset: leaves on the next even one, stats untouched
      rearm();
      start_pause();
      count_pause(-1, 3, hi);
      check_val("E_high_cycles", 32'(hi), 32'd4);
      check_val("E_pause_cycles", 32'(bus_if.pause_cycles), 32'(TIMEOUT));
      check_val("E_timeouts", 32'(bus_if.timeout_count), 32'd1);

      // Reset in the middle of a pause
      rearm();
      start_pause();
      repeat (3) tick();
      apply_reset();

      // Lock after three good frames, cleared by a timeout
      for (int f = 0; f < 3; f++) begin
         rearm();
         start_pause();
         count_pause(4 + 2 * f, -1, hi);
         check_val("L_locked", 32'(bus_if.sync_locked), 32'(f == 2));
      end
      rearm();
      start_pause();
      count_pause(-1, -1, hi);
      check_val("L_unlocked", 32'(bus_if.sync_locked), 32'd0);

      // Randomized frames: lines frozen while paused, HDMI pulses scheduled or spurious
      ln = 0; sub = 0; hdelay = -1; hhigh = 0; hgap = 0; en_off = 0;
      for (int i = 0; i < 12000; i++) begin
         prev_phase = m_phase;
         tick();
         if (m_phase != M_PAUSE) begin
            sub++;
            if (sub == 4) begin
               sub = 0;
               ln  = (ln == 261) ? 0 : ln + 1;
            end
         end
         bus_if.ys           = 9'(ln);
         bus_if.snes_refresh = (sub == 2);
         if (en_off > 0) en_off--;
         else if ($urandom_range(0, 599) == 0) en_off = $urandom_range(1, 8);
         bus_if.enable = (en_off == 0);
         if (m_phase == M_PAUSE && prev_phase != M_PAUSE && $urandom_range(0, 3) != 0)
            hdelay = $urandom_range(0, 14);
         else if (m_phase != M_PAUSE && hdelay < 0 && $urandom_range(0, 199) == 0)
            hdelay = 0;
         if (hhigh > 0) begin
            hhigh--;
            if (hhigh == 0) hgap = 3;
         end else if (hgap > 0) begin
            hgap--;
         end else if (hdelay == 0) begin
            hhigh  = $urandom_range(4, 6);
            hdelay = -1;
         end else if (hdelay > 0) begin
            hdelay--;
         end
         bus_if.hdmi_first_line = (hhigh > 0);
      end

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
